// File: rtl/vga_bram_arb_pkg.sv
// Shared types for the VGA frame-buffer BRAM arbiter: arbitration states,
// read-tag ownership and the tag record carried alongside each BRAM read.
package vga_bram_arb_pkg;

  typedef enum logic [1:0] {
    VID_PRI    = 2'd0,
    HOST_PRI   = 2'd1,
    HOST_FORCE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_VID  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  localparam rd_tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_VID};

  // Width needed to count up to max_wait inclusive; never narrower than 1 bit.
  function automatic int wait_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/vga_bram_rd_tag_pipe.sv
// Tag shift register that travels in lock-step with BRAM reads so the
// returning data can be steered to the requester that issued the read.
module vga_bram_rd_tag_pipe
  import vga_bram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage [DEPTH];

  // Shift one stage per cycle; reset discards every in-flight tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= TAG_IDLE;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/vga_bram_arbiter.sv
// Arbiter sharing the frame-buffer BRAM port between the video scan-out
// prefetcher and the AXI4-Lite host path. Video wins during active display,
// host wins during blanking, and a starvation guard forces one host access
// after HOST_MAX_WAIT stalled cycles.
// Optional: define VGA_BRAM_ARB_STATS_EN to add grant/force statistic counters.
module vga_bram_arbiter
  import vga_bram_arb_pkg::*;
#(
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 32,
  parameter int RD_LAT        = 1,
  parameter int HOST_MAX_WAIT = 16
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                vid_blank,
  input  logic                vid_valid,
  output logic                vid_ready,
  input  logic [ADDR_W-1:0]   vid_addr,
  output logic                vid_rvalid,
  output logic [DATA_W-1:0]   vid_rdata,
  input  logic                host_valid,
  output logic                host_ready,
  input  logic                host_we,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  input  logic [DATA_W/8-1:0] host_be,
  output logic                host_bvalid,
  output logic                host_rvalid,
  output logic [DATA_W-1:0]   host_rdata,
  output logic                bram_en,
  output logic [DATA_W/8-1:0] bram_we,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [DATA_W-1:0]   bram_wdata,
  input  logic [DATA_W-1:0]   bram_rdata
`ifdef VGA_BRAM_ARB_STATS_EN
  ,
  output logic [31:0]         stat_host_grants,
  output logic [31:0]         stat_vid_grants,
  output logic [15:0]         stat_force_cnt
`endif
);

  localparam int BE_W     = DATA_W / 8;
  localparam int WAIT_W   = wait_width(HOST_MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(HOST_MAX_WAIT);
  localparam bit GUARD_EN = (HOST_MAX_WAIT != 0);

  arb_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              vid_acc;
  logic              host_acc;
  logic              host_stall;
  logic              force_enter;
  rd_tag_t           tag_in;
  rd_tag_t           tag_out;

  // Grant decision: forced host, else blanking gives host priority, else video.
  // Both readies are held low while reset is asserted.
  always_comb begin
    vid_ready  = 1'b0;
    host_ready = 1'b0;
    if (ARESETN) begin
      if (state == HOST_FORCE) begin
        host_ready = host_valid;
      end else if (vid_blank) begin
        host_ready = host_valid;
        vid_ready  = vid_valid & ~host_valid;
      end else begin
        vid_ready  = vid_valid;
        host_ready = host_valid & ~vid_valid;
      end
    end
  end

  assign vid_acc    = vid_valid & vid_ready;
  assign host_acc   = host_valid & host_ready;
  assign host_stall = host_valid & ~host_ready;

  // Next value of the host wait counter: clear on grant, saturate at the limit.
  always_comb begin
    wait_nxt = wait_cnt;
    if (host_acc) begin
      wait_nxt = '0;
    end else if (host_stall && (wait_cnt != WAIT_MAX)) begin
      wait_nxt = wait_cnt + 1'b1;
    end
  end

  assign force_enter = GUARD_EN && (state != HOST_FORCE) && host_stall &&
                       (wait_nxt == WAIT_MAX);

  // Arbitration FSM and wait counter; blanking picks the priority every cycle
  // except while a forced host access is pending.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= VID_PRI;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_nxt;
      if (state == HOST_FORCE) begin
        if (host_acc) begin
          state <= vid_blank ? HOST_PRI : VID_PRI;
        end
      end else if (force_enter) begin
        state <= HOST_FORCE;
      end else begin
        state <= vid_blank ? HOST_PRI : VID_PRI;
      end
    end
  end

  // Register the winning request as next cycle's BRAM command.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bram_en     <= 1'b0;
      bram_we     <= '0;
      bram_addr   <= '0;
      bram_wdata  <= '0;
      host_bvalid <= 1'b0;
    end else begin
      bram_en     <= vid_acc | host_acc;
      bram_we     <= '0;
      host_bvalid <= host_acc & host_we;
      if (host_acc) begin
        bram_addr  <= host_addr;
        bram_wdata <= host_wdata;
        if (host_we) begin
          bram_we <= host_be;
        end
      end else if (vid_acc) begin
        bram_addr <= vid_addr;
      end
    end
  end

  assign tag_in.valid = vid_acc | (host_acc & ~host_we);
  assign tag_in.owner = host_acc ? OWN_HOST : OWN_VID;

  vga_bram_rd_tag_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_tag_pipe (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Steer returning read data to its owner; data holds between pulses.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      vid_rvalid  <= 1'b0;
      vid_rdata   <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      vid_rvalid  <= tag_out.valid && (tag_out.owner == OWN_VID);
      host_rvalid <= tag_out.valid && (tag_out.owner == OWN_HOST);
      if (tag_out.valid && (tag_out.owner == OWN_VID)) begin
        vid_rdata <= bram_rdata;
      end
      if (tag_out.valid && (tag_out.owner == OWN_HOST)) begin
        host_rdata <= bram_rdata;
      end
    end
  end

`ifdef VGA_BRAM_ARB_STATS_EN
  // Free-running grant and force-entry counters, wrapping at their width.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      stat_host_grants <= '0;
      stat_vid_grants  <= '0;
      stat_force_cnt   <= '0;
    end else begin
      if (host_acc) stat_host_grants <= stat_host_grants + 32'd1;
      if (vid_acc) stat_vid_grants <= stat_vid_grants + 32'd1;
      if (force_enter) stat_force_cnt <= stat_force_cnt + 16'd1;
    end
  end
`endif

  logic unused_ok;
  assign unused_ok = ^{BE_W[0]};

endmodule
